// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Program-counter register and next-PC selection for the single-cycle
//   datapath. It forms PC+4 and the branch, jump and jump-register targets,
//   selects one of them, and registers the result into pc. A one-entry
//   redirect buffer keeps a redirect that resolves while the fetch is
//   stalled. The buffered target is applied at the first unstalled edge.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   stall            hold pc; a redirect seen now is buffered, not lost
//   branch, bne      beq / bne in flight
//   zero             ALU zero flag for the current instruction
//   jump, jr         j/jal and jr in flight
//   imm_sl2          sign-extended branch offset, already shifted left by 2
//   jidx             jump index field instr[25:0]
//   jr_target        register operand for jr
//   pc               current PC (registered)
//   pc_plus4         pc + 4 (combinational, used for the jal link)
//   redirect_pending buffered redirect waiting for the stall to drop
//   misalign         one-cycle pulse: a jr target with nonzero low bits was applied
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | no buffered redirect; pc advances or redirects when unstalled
// HELD  | redirect captured during a stall; applied when the stall drops

module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] imm_sl2,
  input  logic [25:0] jidx,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [31:0] pc_n;
  logic [31:0] pend_tgt;
  logic [31:0] pend_tgt_n;
  logic        pend_mis;
  logic        pend_mis_n;
  logic        misalign_n;

  logic        taken;
  logic        req;
  logic        jr_mis;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] tgt;

  // Target formation. All additions wrap modulo 2^32.
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + imm_sl2;
  assign j_tgt    = {pc_plus4[31:28], jidx, 2'b00};
  assign jr_tgt   = {jr_target[31:2], 2'b00};

  assign taken  = (branch & zero) | (bne & ~zero);
  assign req    = jr | jump | taken;
  // Only a jr can carry a misaligned target; j and branch targets are
  // always word-aligned by construction.
  assign jr_mis = jr & (jr_target[1:0] != 2'b00);

  // Priority: jr > jump > taken branch.
  always_comb begin
    tgt = br_tgt;
    if (jr) begin
      tgt = jr_tgt;
    end else if (jump) begin
      tgt = j_tgt;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_tgt_n = pend_tgt;
    pend_mis_n = pend_mis;
    misalign_n = 1'b0;

    unique case (state)
      RUN: begin
        if (!stall) begin
          pc_n       = req ? tgt : pc_plus4;
          misalign_n = jr_mis;
        end else if (req) begin
          state_n    = HELD;
          pend_tgt_n = tgt;
          pend_mis_n = jr_mis;
        end
      end
      HELD: begin
        // Requests seen here belong to an instruction behind the buffered
        // redirect and are dropped. The first captured redirect wins.
        if (!stall) begin
          state_n    = RUN;
          pc_n       = pend_tgt;
          misalign_n = pend_mis;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pend_tgt <= 32'h0000_0000;
      pend_mis <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend_tgt <= pend_tgt_n;
      pend_mis <= pend_mis_n;
      misalign <= misalign_n;
    end
  end

  assign redirect_pending = (state == HELD);

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selector for the single-cycle datapath. It consumes the word-shifted, sign-extended branch offset produced by the shift-left-by-2 stage, adds it to PC+4 to form the branch target, and also forms jump and jump-register targets. It holds the selected value in the PC register that drives instruction memory. A one-entry redirect buffer keeps a branch or jump that resolves during a stall, so the redirect is applied when the stall releases.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned.
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC (instruction-memory wait); redirects are buffered, not lost.
- branch  input  1  current instruction is beq.
- bne  input  1  current instruction is bne.
- zero  input  1  ALU zero flag for the current instruction.
- jump  input  1  current instruction is j/jal.
- jr  input  1  current instruction is jr.
- imm_sl2  input  32  sign-extended immediate shifted left by 2 (word offset in bytes).
- jidx  input  26  jump index field, instr[25:0].
- jr_target  input  32  register operand for jr.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4 (combinational, used for the jal link).
- redirect_pending  output  1  buffered redirect waiting for the stall to release (registered).
- misalign  output  1  one-cycle pulse: a jr target with nonzero bits [1:0] was applied (registered).

## Operation

- Width rules:
  - pc_plus4 = pc + 32'd4, mod 2^32.
  - Branch target = pc_plus4 + imm_sl2, mod 2^32, no overflow flag.
  - Jump target = {pc_plus4[31:28], jidx, 2'b00}.
  - JR target = {jr_target[31:2], 2'b00}.
- taken = (branch & zero) | (bne & ~zero).
- Redirect request priority: jr > jump > taken. The selected target is tgt; req = jr | jump | taken.
- Cycle behaviour when not in reset:
  - stall=0, redirect_pending=1: pc <= pend_tgt and pending clears. Requests in this cycle are ignored, because they belong to a stale instruction.
  - stall=0, redirect_pending=0: pc <= req ? tgt : pc_plus4.
  - stall=1, redirect_pending=0, req=1: pc holds; pend_tgt <= tgt; redirect_pending <= 1; pend_mis <= jr & (jr_target[1:0]!=0).
  - stall=1, redirect_pending=1: pc and pend_tgt hold. The first buffered redirect wins and later requests are ignored.
  - stall=1, req=0: pc holds.
- misalign:
  - Asserted for exactly one cycle, on the cycle after the edge that loads a jr target with nonzero low bits into pc.
  - For a buffered jr, this is the edge that consumes the pending redirect.
- Internal states:
  - RUN: redirect_pending=0.
  - HELD: redirect_pending=1.
  - RUN->HELD on stall & req.
  - HELD->RUN on ~stall.
  - rst forces RUN from either state.

## Timing

- Reset (rst=1 at an edge):
  - pc=RESET_PC, redirect_pending=0, misalign=0, pend_tgt=0.
  - Reset overrides stall and all requests.
  - Reset during HELD discards the buffered redirect.
- The PC update takes effect one cycle after the inputs are sampled. pc_plus4 follows pc combinationally in the same cycle.
- No combinational path from any input to pc, redirect_pending or misalign.
- Stall release: the pending target appears on pc at the first edge sampled with stall=0. There is no bubble cycle.
- Wrap-around:
  - pc=32'hFFFF_FFFC with no request goes to 32'h0000_0000.
  - A negative imm_sl2 wraps modulo 2^32.

## Test plan

- Reset and sequential fetch: rst 1 cycle with RESET_PC=0, then 3 idle cycles -> pc 0, 4, 8, 12. Assert pc=0xFFFFFFFC, then 1 idle cycle -> pc=0.
- Branch arithmetic and priority:
  - pc=0x100, branch=1, zero=1, imm_sl2=0xFFFFFFF0 -> pc=0xF4.
  - Same with zero=0 -> 0x104.
  - bne=1, zero=0, imm_sl2=0x20 -> 0x124.
  - jump=1, jr=1, jr_target=0x400 in the same cycle -> pc=0x400.
- Jump: pc=0x3000_0010, jump=1, jidx=26'h0000040 -> pc=0x3000_0100.
- Stall buffering:
  - pc=0x200, stall=1 with jump to 0x80 for 1 cycle, then a branch request while still stalled for 2 cycles.
  - redirect_pending=1 from the next cycle and pc stays 0x200.
  - Release stall while presenting a new branch request -> pc=0x80, pending=0, the new request is ignored.
- Misalign: jr=1, jr_target=0x1003 -> pc=0x1000, misalign high exactly 1 cycle. A buffered jr to 0x2002 pulses misalign only after stall release.
- Reset mid-stall: enter HELD with pend_tgt=0x500, assert rst -> pc=RESET_PC, pending=0. After release, pc continues RESET_PC+4 and 0x500 never appears.
